// File: rtl/inbuf_pkg.sv
// Shared definitions for the input conditioning front end.
//   - DEF_* : default synchroniser depth, debounce length and counter width
//   - merge_st_e : merge FSM state encoding
package inbuf_pkg;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_DEB_CYCLES  = 4;
    localparam int DEF_CNT_W       = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN1 = 2'b01,
        ST_OWN2 = 2'b10
    } merge_st_e;
endpackage

// File: rtl/inbuf_debounce.sv
// One input channel: SYNC_STAGES-deep synchroniser followed by a debounce
// counter that accepts a new level only after it has persisted for
// DEB_CYCLES consecutive synchronised cycles.
// Build option: INBUF_DEBOUNCE_EN defined builds the counter; undefined
// passes the synchroniser output straight through (busy tied low).
// Ports:
//   clk, rst_n : clock, async active-low reset
//   in         : raw asynchronous input
//   deb        : clean level
//   busy       : a debounce count is in progress
module inbuf_debounce
    import inbuf_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic deb,
    output logic busy
);

    if (SYNC_STAGES < 2 || DEB_CYCLES < 1 || (1 << CNT_W) <= DEB_CYCLES) begin : g_param_chk
        $error("inbuf_debounce: illegal SYNC_STAGES/DEB_CYCLES/CNT_W");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   syn;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], in};
    end

    assign syn = sync_q[SYNC_STAGES-1];

`ifdef INBUF_DEBOUNCE_EN
    logic             deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter runs only while syn disagrees with the accepted level; any
    // return to agreement drops it back to 0, so short glitches vanish.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (syn != deb_q) begin
            if (cnt_q >= CNT_W'(DEB_CYCLES - 1)) deb_d = syn;
            else                                 cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            deb_q <= deb_d;
            cnt_q <= cnt_d;
        end
    end

    assign deb  = deb_q;
    assign busy = |cnt_q;
`else
    assign deb  = syn;
    assign busy = 1'b0;
`endif

endmodule

// File: rtl/inbuf_debounce_merge.sv
// Input conditioning front end: two noisy asynchronous inputs are each
// synchronised and debounced, then merged into one registered level.
// An ownership FSM guarantees exactly one channel drives the merged level;
// handover between channels never shows a 0 cycle on out.
// Build option: INBUF_DEBOUNCE_EN enables the debounce counters.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   in1, in2   : raw asynchronous inputs
//   out        : merged level (registered)
//   owner      : 0 = channel 1 owns out, 1 = channel 2 (registered)
//   stable     : no debounce count pending on either channel
module inbuf_debounce_merge
    import inbuf_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in1,
    input  logic in2,
    output logic out,
    output logic owner,
    output logic stable
);

    logic      deb1, deb2, busy1, busy2;
    merge_st_e state_q, state_d;
    logic      out_q, owner_q;

    inbuf_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_ch1 (
        .clk(clk), .rst_n(rst_n), .in(in1), .deb(deb1), .busy(busy1)
    );

    inbuf_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_ch2 (
        .clk(clk), .rst_n(rst_n), .in(in2), .deb(deb2), .busy(busy2)
    );

    // Owner keeps the net while its level holds; on release the other
    // channel takes over directly if it is already high (channel 1 wins ties
    // from IDLE).
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (deb1)      state_d = ST_OWN1;
                else if (deb2) state_d = ST_OWN2;
            end
            ST_OWN1: begin
                if (!deb1) state_d = deb2 ? ST_OWN2 : ST_IDLE;
            end
            ST_OWN2: begin
                if (!deb2) state_d = deb1 ? ST_OWN1 : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered alongside the state so they change on the same
    // edge as the ownership decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            out_q   <= 1'b0;
            owner_q <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= (state_d != ST_IDLE);
            owner_q <= (state_d == ST_OWN2);
        end
    end

    assign out    = out_q;
    assign owner  = owner_q;
    assign stable = ~(busy1 | busy2);

endmodule

// File: tb/tb_inbuf_debounce_merge.sv
module tb_inbuf_debounce_merge;
    localparam int SS = 2;
    localparam int DC = 4;
`ifdef INBUF_DEBOUNCE_EN
    localparam int LAT    = SS + DC + 1;
    localparam bit DEB_ON = 1'b1;
`else
    localparam int LAT    = SS + 1;
    localparam bit DEB_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in1 = 1'b0;
    logic in2 = 1'b0;
    logic out, owner, stable;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    inbuf_debounce_merge #(.SYNC_STAGES(SS), .DEB_CYCLES(DC), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .in1(in1), .in2(in2),
        .out(out), .owner(owner), .stable(stable)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected stable after edge e when one input starts a transition
    // from a quiet state before edge 1: counting after edges SS+1..SS+DC-1.
    function automatic logic exp_stable(input int e);
        return !(DEB_ON && e >= SS + 1 && e <= SS + DC - 1);
    endfunction

    initial begin
        // reset held with an active input: nothing may move
        in1 = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            chk("rst_out", out, 0);
        end
        chk("rst_owner", owner, 0);
        chk("rst_stable", stable, 1);
        in1 = 1'b0;
        rst_n = 1'b1;
        tick();
        tick();

        // rise latency on channel 1
        in1 = 1'b1;
        for (int e = 1; e <= LAT; e++) begin
            tick();
            chk("rise_out", out, e >= LAT);
            chk("rise_owner", owner, 0);
            chk("rise_stable", stable, exp_stable(e));
        end

        // in1 falls and in2 rises together: direct OWN1 -> OWN2
        in1 = 1'b0;
        in2 = 1'b1;
        for (int e = 1; e <= LAT; e++) begin
            tick();
            chk("swap_out", out, 1);
            chk("swap_owner", owner, e >= LAT);
        end

        // fall latency on channel 2
        in2 = 1'b0;
        for (int e = 1; e <= LAT; e++) begin
            tick();
            chk("fall_out", out, e < LAT);
            chk("fall_owner", owner, e < LAT);
        end
        tick();
        tick();
        chk("idle_stable", stable, 1);

`ifdef INBUF_DEBOUNCE_EN
        // 3-cycle glitch on in1 is filtered out
        in1 = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            chk("glitch_out", out, 0);
            chk("glitch_stable", stable, exp_stable(e));
            if (e == 3) in1 = 1'b0;
        end
`else
        // 1-cycle pulse on in2 passes straight through
        in2 = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            if (e == 1) in2 = 1'b0;
            chk("pulse_out", out, e == 3);
            chk("pulse_owner", owner, e == 3);
            chk("pulse_stable", stable, 1);
        end
`endif

        // both rise together: channel 1 wins
        in1 = 1'b1;
        in2 = 1'b1;
        for (int e = 1; e <= LAT; e++) begin
            tick();
            chk("both_out", out, e >= LAT);
            chk("both_owner", owner, 0);
        end

        // handover to channel 2 with no gap
        in1 = 1'b0;
        for (int e = 1; e <= LAT; e++) begin
            tick();
            chk("hand_out", out, 1);
            chk("hand_owner", owner, e >= LAT);
        end

        // asynchronous reset mid-operation
        rst_n = 1'b0;
        #1;
        chk("mrst_out", out, 0);
        chk("mrst_owner", owner, 0);
        chk("mrst_stable", stable, 1);
        #3;
        rst_n = 1'b1;
        for (int e = 1; e <= LAT; e++) begin
            tick();
            chk("rec_out", out, e >= LAT);
            chk("rec_owner", owner, e >= LAT);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
